i2s_rx_stream_ctrl: RTL and testbench

Sequencer and stream packer for the I2S slave receiver. It enables the receiver, waits for bit-clock activity, and aligns to left/right frame boundaries. It packs completed sample pairs into 32-bit words for the downstream RX FIFO and reports clock-loss and overflow as sticky status and interrupt. The block sits between the Wishbone register bank and the I2S RX FIFO, entirely in the fabric clock domain.

---
 rtl/i2s_rx_stream_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_i2s_rx_stream_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_stream_ctrl.sv
// I2S slave receiver sequencer and L/R stream packer, fabric clock domain only.
// Define I2S_RX_CTRL_OVF_CNT_EN to build the saturating dropped-word counter on ovf_cnt_o.
module i2s_rx_stream_ctrl #(
    parameter int ARM_TIMEOUT = 1024,
    parameter int ACT_CYCLES  = 4,
    parameter int OVF_CNT_W   = 8
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_n_i,
    input  logic                 rx_en_i,
    input  logic [1:0]           mode_i,
    input  logic                 err_clr_i,
    input  logic                 i2s_dis_i,
    input  logic                 push_left_i,
    input  logic                 push_right_i,
    input  logic [15:0]          data_left_i,
    input  logic [15:0]          data_right_i,
    input  logic                 fifo_full_i,
    output logic                 I2S_S_EN_o,
    output logic                 fifo_push_o,
    output logic [31:0]          fifo_data_o,
    output logic [1:0]           state_o,
    output logic                 clk_lost_o,
    output logic                 ovf_o,
    output logic [OVF_CNT_W-1:0] ovf_cnt_o,
    output logic                 irq_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;

    localparam int ACT_W = $clog2(ACT_CYCLES + 1);
    localparam int TMO_W = $clog2(ARM_TIMEOUT);
    localparam logic [ACT_W-1:0] ACT_LAST = ACT_W'(ACT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [ACT_W-1:0] act_q, act_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [15:0]      hold_q, hold_d;
    logic             lv_q, lv_d;
    logic             lost_set;
    logic             emit;
    logic [31:0]      emit_word;
    logic             ovf_set;
    logic             write_d;
    logic             lost_d, ovf_d;
    logic             mono_mode;

    logic             en_q;
    logic             push_q;
    logic [31:0]      data_q;
    logic             lost_q;
    logic             ovf_q;
    logic             irq_q;

    assign mono_mode = (mode_q == MODE_LEFT) || (mode_q == MODE_RIGHT);

    // Sequencer: dropping rx_en_i wins over everything; ARM waits for a run of
    // bit-clock activity and gives up after the timeout window.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        act_d    = act_q;
        tmo_d    = tmo_q;
        lost_set = 1'b0;
        if (!rx_en_i) begin
            state_d = ST_IDLE;
            act_d   = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    mode_d  = mode_i;
                    act_d   = '0;
                    tmo_d   = '0;
                end
                ST_ARM: begin
                    act_d = i2s_dis_i ? '0 : act_q + ACT_W'(1);
                    tmo_d = tmo_q + TMO_W'(1);
                    if (!i2s_dis_i && (act_q == ACT_LAST)) begin
                        state_d = mono_mode ? ST_RUN : ST_SYNC;
                        act_d   = '0;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d  = ST_IDLE;
                        lost_set = 1'b1;
                        act_d    = '0;
                        tmo_d    = '0;
                    end
                end
                ST_SYNC: begin
                    if (i2s_dis_i) begin
                        state_d  = ST_ARM;
                        lost_set = 1'b1;
                    end else if (push_left_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i2s_dis_i) begin
                        state_d  = ST_ARM;
                        lost_set = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Packer: in stereo the right half is resolved against the old hold value
    // before a coincident left overwrites it.
    always_comb begin
        hold_d    = hold_q;
        lv_d      = lv_q;
        emit      = 1'b0;
        emit_word = '0;
        if (!rx_en_i || i2s_dis_i) begin
            lv_d = 1'b0;
        end else if (state_q == ST_SYNC) begin
            if (push_left_i) begin
                hold_d = data_left_i;
                lv_d   = 1'b1;
            end
        end else if (state_q == ST_RUN) begin
            if (mode_q == MODE_LEFT) begin
                if (push_left_i) begin
                    emit      = 1'b1;
                    emit_word = {data_left_i, 16'h0000};
                end
            end else if (mode_q == MODE_RIGHT) begin
                if (push_right_i) begin
                    emit      = 1'b1;
                    emit_word = {16'h0000, data_right_i};
                end
            end else begin
                if (push_right_i && lv_q) begin
                    emit      = 1'b1;
                    emit_word = {hold_q, data_right_i};
                    lv_d      = 1'b0;
                end
                if (push_left_i) begin
                    hold_d = data_left_i;
                    lv_d   = 1'b1;
                end
            end
        end else begin
            lv_d = 1'b0;
        end
    end

    assign write_d = emit && !fifo_full_i;
    assign ovf_set = emit && fifo_full_i;
    assign lost_d  = lost_set || (lost_q && !err_clr_i);
    assign ovf_d   = ovf_set || (ovf_q && !err_clr_i);

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'b00;
            act_q   <= '0;
            tmo_q   <= '0;
            hold_q  <= 16'h0000;
            lv_q    <= 1'b0;
            en_q    <= 1'b0;
            push_q  <= 1'b0;
            data_q  <= 32'h0000_0000;
            lost_q  <= 1'b0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            act_q   <= act_d;
            tmo_q   <= tmo_d;
            hold_q  <= hold_d;
            lv_q    <= lv_d;
            en_q    <= (state_d != ST_IDLE);
            push_q  <= write_d;
            if (write_d) begin
                data_q <= emit_word;
            end
            lost_q  <= lost_d;
            ovf_q   <= ovf_d;
            irq_q   <= lost_d || ovf_d;
        end
    end

`ifdef I2S_RX_CTRL_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            ovf_cnt_q <= '0;
        end else if (ovf_set) begin
            if (err_clr_i) begin
                ovf_cnt_q <= OVF_CNT_W'(1);
            end else if (ovf_cnt_q != '1) begin
                ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
            end
        end else if (err_clr_i) begin
            ovf_cnt_q <= '0;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = '0;
`endif

    assign I2S_S_EN_o  = en_q;
    assign fifo_push_o = push_q;
    assign fifo_data_o = data_q;
    assign state_o     = state_q;
    assign clk_lost_o  = lost_q;
    assign ovf_o       = ovf_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_i2s_rx_stream_ctrl.sv
// Self-checking bench for i2s_rx_stream_ctrl: directed scenarios plus a randomized
// stereo stream scored against a pair-forming reference model.
module tb_i2s_rx_stream_ctrl;

    localparam int ARM_TIMEOUT = 1024;
    localparam int ACT_CYCLES  = 4;
    localparam int OVF_CNT_W   = 8;
    localparam int OVF_MAX     = (1 << OVF_CNT_W) - 1;

    logic                 WBs_CLK_i = 1'b0;
    logic                 WBs_RST_n_i;
    logic                 rx_en_i;
    logic [1:0]           mode_i;
    logic                 err_clr_i;
    logic                 i2s_dis_i;
    logic                 push_left_i;
    logic                 push_right_i;
    logic [15:0]          data_left_i;
    logic [15:0]          data_right_i;
    logic                 fifo_full_i;
    logic                 I2S_S_EN_o;
    logic                 fifo_push_o;
    logic [31:0]          fifo_data_o;
    logic [1:0]           state_o;
    logic                 clk_lost_o;
    logic                 ovf_o;
    logic [OVF_CNT_W-1:0] ovf_cnt_o;
    logic                 irq_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          drops;
    int          wait_cnt;
    logic        have_l;
    logic [15:0] hold;
    logic        rl, rr, rfull, exp_push;
    logic [15:0] rdl, rdr;
    logic [31:0] exp_word;

    i2s_rx_stream_ctrl #(
        .ARM_TIMEOUT(ARM_TIMEOUT),
        .ACT_CYCLES (ACT_CYCLES),
        .OVF_CNT_W  (OVF_CNT_W)
    ) dut (
        .WBs_CLK_i   (WBs_CLK_i),
        .WBs_RST_n_i (WBs_RST_n_i),
        .rx_en_i     (rx_en_i),
        .mode_i      (mode_i),
        .err_clr_i   (err_clr_i),
        .i2s_dis_i   (i2s_dis_i),
        .push_left_i (push_left_i),
        .push_right_i(push_right_i),
        .data_left_i (data_left_i),
        .data_right_i(data_right_i),
        .fifo_full_i (fifo_full_i),
        .I2S_S_EN_o  (I2S_S_EN_o),
        .fifo_push_o (fifo_push_o),
        .fifo_data_o (fifo_data_o),
        .state_o     (state_o),
        .clk_lost_o  (clk_lost_o),
        .ovf_o       (ovf_o),
        .ovf_cnt_o   (ovf_cnt_o),
        .irq_o       (irq_o)
    );

    always #5 WBs_CLK_i = ~WBs_CLK_i;

    function automatic logic [31:0] expCnt(input int n);
`ifdef I2S_RX_CTRL_OVF_CNT_EN
        return (n > OVF_MAX) ? 32'(OVF_MAX) : 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge WBs_CLK_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic [15:0] dl, input logic [15:0] dr);
        push_left_i  = l;
        push_right_i = r;
        data_left_i  = dl;
        data_right_i = dr;
        tick();
        push_left_i  = 1'b0;
        push_right_i = 1'b0;
    endtask

    task automatic clearErrors();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
    endtask

    task automatic waitArmExit(input logic [31:0] exp_state, input string tag);
        repeat (ACT_CYCLES - 1) tick();
        checkOutput({tag, "_still_arm"}, 32'(state_o), 32'd1);
        tick();
        checkOutput({tag, "_arm_exit"}, 32'(state_o), exp_state);
    endtask

    task automatic startStream(input logic [1:0] m, input string tag);
        rx_en_i = 1'b0;
        tick();
        mode_i  = m;
        rx_en_i = 1'b1;
        tick();
        checkOutput({tag, "_arm"}, 32'(state_o), 32'd1);
        mode_i = ~m;
        waitArmExit((m == 2'b01 || m == 2'b10) ? 32'd3 : 32'd2, tag);
    endtask

    initial begin
        WBs_RST_n_i  = 1'b0;
        rx_en_i      = 1'b0;
        mode_i       = 2'b00;
        err_clr_i    = 1'b0;
        i2s_dis_i    = 1'b0;
        push_left_i  = 1'b0;
        push_right_i = 1'b0;
        data_left_i  = 16'h0;
        data_right_i = 16'h0;
        fifo_full_i  = 1'b0;
        repeat (3) tick();

        checkOutput("rst_state", 32'(state_o), 32'd0);
        checkOutput("rst_en", 32'(I2S_S_EN_o), 32'd0);
        checkOutput("rst_push", 32'(fifo_push_o), 32'd0);
        checkOutput("rst_data", fifo_data_o, 32'd0);
        checkOutput("rst_lost", 32'(clk_lost_o), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_o), 32'd0);
        checkOutput("rst_cnt", 32'(ovf_cnt_o), 32'd0);
        checkOutput("rst_irq", 32'(irq_o), 32'd0);
        WBs_RST_n_i = 1'b1;
        tick();
        checkOutput("idle_hold", 32'(state_o), 32'd0);

        // Stereo happy path
        mode_i  = 2'b00;
        rx_en_i = 1'b1;
        tick();
        checkOutput("happy_arm", 32'(state_o), 32'd1);
        checkOutput("happy_en", 32'(I2S_S_EN_o), 32'd1);
        waitArmExit(32'd2, "happy");
        applyStimulus(1'b1, 1'b0, 16'hA5A5, 16'h0000);
        checkOutput("happy_run", 32'(state_o), 32'd3);
        checkOutput("happy_nopush_left", 32'(fifo_push_o), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h3C3C);
        checkOutput("happy_push", 32'(fifo_push_o), 32'd1);
        checkOutput("happy_data", fifo_data_o, 32'hA5A5_3C3C);
        tick();
        checkOutput("happy_push_single", 32'(fifo_push_o), 32'd0);
        checkOutput("happy_data_hold", fifo_data_o, 32'hA5A5_3C3C);

        // Alignment: right pulse in SYNC is ignored
        startStream(2'b00, "align");
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h1111);
        checkOutput("align_r_ignored", 32'(fifo_push_o), 32'd0);
        checkOutput("align_still_sync", 32'(state_o), 32'd2);
        applyStimulus(1'b1, 1'b0, 16'h2222, 16'h0000);
        checkOutput("align_l_nopush", 32'(fifo_push_o), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h3333);
        checkOutput("align_push", 32'(fifo_push_o), 32'd1);
        checkOutput("align_data", fifo_data_o, 32'h2222_3333);

        // Simultaneous left+right: right resolves against old hold first
        applyStimulus(1'b1, 1'b1, 16'hAAAA, 16'hBBBB);
        checkOutput("simul_orphan_r", 32'(fifo_push_o), 32'd0);
        applyStimulus(1'b1, 1'b1, 16'hCCCC, 16'hDDDD);
        checkOutput("simul_push", 32'(fifo_push_o), 32'd1);
        checkOutput("simul_data", fifo_data_o, 32'hAAAA_DDDD);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'hEEEE);
        checkOutput("simul_next_push", 32'(fifo_push_o), 32'd1);
        checkOutput("simul_next_data", fifo_data_o, 32'hCCCC_EEEE);

        // Clock timeout in ARM
        rx_en_i = 1'b0;
        tick();
        i2s_dis_i = 1'b1;
        rx_en_i   = 1'b1;
        tick();
        checkOutput("tmo_arm", 32'(state_o), 32'd1);
        checkOutput("tmo_lost_early", 32'(clk_lost_o), 32'd0);
        wait_cnt = 0;
        while (state_o != 2'd0 && wait_cnt < 2 * ARM_TIMEOUT) begin
            tick();
            wait_cnt++;
        end
        rx_en_i = 1'b0;
        checkOutput("tmo_cycles", 32'(wait_cnt), 32'(ARM_TIMEOUT));
        checkOutput("tmo_lost", 32'(clk_lost_o), 32'd1);
        checkOutput("tmo_irq", 32'(irq_o), 32'd1);
        checkOutput("tmo_state", 32'(state_o), 32'd0);
        checkOutput("tmo_en", 32'(I2S_S_EN_o), 32'd0);
        i2s_dis_i = 1'b0;
        clearErrors();
        checkOutput("tmo_clr_lost", 32'(clk_lost_o), 32'd0);
        checkOutput("tmo_clr_irq", 32'(irq_o), 32'd0);

        // Overflow
        startStream(2'b00, "ovf");
        fifo_full_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(16'h0100 + i), 16'h0000);
            applyStimulus(1'b0, 1'b1, 16'h0000, 16'(16'h0200 + i));
            checkOutput("ovf_no_push", 32'(fifo_push_o), 32'd0);
        end
        checkOutput("ovf_flag", 32'(ovf_o), 32'd1);
        checkOutput("ovf_irq", 32'(irq_o), 32'd1);
        checkOutput("ovf_cnt3", 32'(ovf_cnt_o), expCnt(3));
        fifo_full_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h5678);
        checkOutput("ovf_release_push", 32'(fifo_push_o), 32'd1);
        checkOutput("ovf_release_data", fifo_data_o, 32'h1234_5678);
        checkOutput("ovf_sticky", 32'(ovf_o), 32'd1);
        fifo_full_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000);
        err_clr_i = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0002);
        err_clr_i = 1'b0;
        checkOutput("ovf_setwins_flag", 32'(ovf_o), 32'd1);
        checkOutput("ovf_setwins_cnt", 32'(ovf_cnt_o), expCnt(1));
        fifo_full_i = 1'b0;
        clearErrors();
        checkOutput("ovf_clr_flag", 32'(ovf_o), 32'd0);
        checkOutput("ovf_clr_cnt", 32'(ovf_cnt_o), 32'd0);
        checkOutput("ovf_clr_irq", 32'(irq_o), 32'd0);

        // Mono modes (mode_i is changed after latching and must be ignored)
        startStream(2'b01, "monoL");
        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000);
        checkOutput("monoL_push1", 32'(fifo_push_o), 32'd1);
        checkOutput("monoL_data1", fifo_data_o, 32'h0001_0000);
        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000);
        checkOutput("monoL_push2", 32'(fifo_push_o), 32'd1);
        checkOutput("monoL_data2", fifo_data_o, 32'h0002_0000);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'hFFFF);
        checkOutput("monoL_r_ignored", 32'(fifo_push_o), 32'd0);
        startStream(2'b10, "monoR");
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h00AB);
        checkOutput("monoR_push", 32'(fifo_push_o), 32'd1);
        checkOutput("monoR_data", fifo_data_o, 32'h0000_00AB);
        applyStimulus(1'b1, 1'b0, 16'h7777, 16'h0000);
        checkOutput("monoR_l_ignored", 32'(fifo_push_o), 32'd0);

        // Abort with a pending half pair, then clean restart
        startStream(2'b00, "abort");
        applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000);
        rx_en_i = 1'b0;
        tick();
        checkOutput("abort_state", 32'(state_o), 32'd0);
        checkOutput("abort_en", 32'(I2S_S_EN_o), 32'd0);
        checkOutput("abort_nopush", 32'(fifo_push_o), 32'd0);
        startStream(2'b00, "restart");
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h5555);
        checkOutput("restart_r_ignored", 32'(fifo_push_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h6666, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h7777);
        checkOutput("restart_push", 32'(fifo_push_o), 32'd1);
        checkOutput("restart_data", fifo_data_o, 32'h6666_7777);

        // Clock loss while running
        i2s_dis_i = 1'b1;
        tick();
        i2s_dis_i = 1'b0;
        checkOutput("loss_lost", 32'(clk_lost_o), 32'd1);
        checkOutput("loss_irq", 32'(irq_o), 32'd1);
        checkOutput("loss_state", 32'(state_o), 32'd1);
        checkOutput("loss_en", 32'(I2S_S_EN_o), 32'd1);
        waitArmExit(32'd2, "loss");
        applyStimulus(1'b1, 1'b0, 16'h0A0A, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0B0B);
        checkOutput("loss_resume_push", 32'(fifo_push_o), 32'd1);
        checkOutput("loss_resume_data", fifo_data_o, 32'h0A0A_0B0B);
        clearErrors();

        // Randomized stereo stream (mode 11) against the pairing model
        startStream(2'b11, "rnd");
        clearErrors();
        rdl = 16'($urandom);
        applyStimulus(1'b1, 1'b0, rdl, 16'h0000);
        hold   = rdl;
        have_l = 1'b1;
        drops  = 0;
        for (int i = 0; i < 400; i++) begin
            rl    = ($urandom_range(2) == 0);
            rr    = ($urandom_range(2) == 0);
            rfull = ($urandom_range(3) == 0);
            rdl   = 16'($urandom);
            rdr   = 16'($urandom);
            exp_push = 1'b0;
            exp_word = 32'h0;
            if (rr && have_l) begin
                if (rfull) drops++;
                else begin
                    exp_push = 1'b1;
                    exp_word = {hold, rdr};
                end
                have_l = 1'b0;
            end
            if (rl) begin
                hold   = rdl;
                have_l = 1'b1;
            end
            fifo_full_i = rfull;
            applyStimulus(rl, rr, rdl, rdr);
            checkOutput("rnd_push", 32'(fifo_push_o), 32'(exp_push));
            if (exp_push) checkOutput("rnd_data", fifo_data_o, exp_word);
        end
        fifo_full_i = 1'b0;
        checkOutput("rnd_ovf", 32'(ovf_o), 32'(drops > 0));
        checkOutput("rnd_cnt", 32'(ovf_cnt_o), expCnt(drops));
        checkOutput("rnd_irq", 32'(irq_o), 32'(drops > 0));

        // Counter saturation
        clearErrors();
        fifo_full_i = 1'b1;
        for (int i = 0; i < OVF_MAX + 5; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0F0F, 16'h0000);
            applyStimulus(1'b0, 1'b1, 16'h0000, 16'hF0F0);
        end
        fifo_full_i = 1'b0;
        checkOutput("sat_cnt", 32'(ovf_cnt_o), expCnt(OVF_MAX + 5));
        checkOutput("sat_ovf", 32'(ovf_o), 32'd1);
        clearErrors();

        // Reset asserted with a completing right pulse in flight
        applyStimulus(1'b1, 1'b0, 16'h1357, 16'h0000);
        push_right_i = 1'b1;
        data_right_i = 16'h2468;
        WBs_RST_n_i  = 1'b0;
        #1;
        checkOutput("midrst_state", 32'(state_o), 32'd0);
        checkOutput("midrst_en", 32'(I2S_S_EN_o), 32'd0);
        tick();
        push_right_i = 1'b0;
        checkOutput("midrst_nopush", 32'(fifo_push_o), 32'd0);
        checkOutput("midrst_data", fifo_data_o, 32'd0);
        WBs_RST_n_i = 1'b1;
        tick();
        checkOutput("midrst_rearm", 32'(state_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
